// File: rtl/cond_unit.sv
// cond_unit: architectural NZCV flag register, condition evaluation and
// write-enable gating for the multi-cycle ARM datapath.
//
// Timing summary:
//   - The condition is evaluated combinationally from Cond and the stored
//     flags, never from ALUFlags.
//   - The result is registered into CondEx on every rising edge, so the
//     decode cycle's Cond governs the write enables from the next cycle on.
//   - Flag writes are qualified by the registered CondEx, which keeps a
//     suppressed instruction from touching the flags.
//   - An evaluation in the same cycle as a flag write sees the old flags.
module cond_unit #(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,     // asynchronous, active-low
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,  // {N,Z,C,V}
    input  logic [1:0] FlagW,     // [1]: N,Z  [0]: C,V
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags      // {N,Z,C,V}
);

    // Condition field encodings
    localparam logic [3:0] C_EQ = 4'b0000;
    localparam logic [3:0] C_NE = 4'b0001;
    localparam logic [3:0] C_CS = 4'b0010;
    localparam logic [3:0] C_CC = 4'b0011;
    localparam logic [3:0] C_MI = 4'b0100;
    localparam logic [3:0] C_PL = 4'b0101;
    localparam logic [3:0] C_VS = 4'b0110;
    localparam logic [3:0] C_VC = 4'b0111;
    localparam logic [3:0] C_HI = 4'b1000;
    localparam logic [3:0] C_LS = 4'b1001;
    localparam logic [3:0] C_GE = 4'b1010;
    localparam logic [3:0] C_LT = 4'b1011;
    localparam logic [3:0] C_GT = 4'b1100;
    localparam logic [3:0] C_LE = 4'b1101;
    localparam logic [3:0] C_AL = 4'b1110;

    logic [3:0] r_flags;
    logic       r_cond_ex;

    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;
    logic       w_ge;
    logic       w_hi;
    logic       w_cond_true;
    logic       w_wr_nz;
    logic       w_wr_cv;

    // Individual flag bits of the stored register
    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    // Shared terms used by paired condition codes
    assign w_ge = (w_n == w_v);
    assign w_hi = w_c & ~w_z;

    // Evaluate the condition field against the stored (pre-update) flags
    always_comb begin
        w_cond_true = 1'b0;
        unique case (Cond)
            C_EQ:    w_cond_true = w_z;
            C_NE:    w_cond_true = ~w_z;
            C_CS:    w_cond_true = w_c;
            C_CC:    w_cond_true = ~w_c;
            C_MI:    w_cond_true = w_n;
            C_PL:    w_cond_true = ~w_n;
            C_VS:    w_cond_true = w_v;
            C_VC:    w_cond_true = ~w_v;
            C_HI:    w_cond_true = w_hi;
            C_LS:    w_cond_true = ~w_hi;
            C_GE:    w_cond_true = w_ge;
            C_LT:    w_cond_true = ~w_ge;
            C_GT:    w_cond_true = ~w_z & w_ge;
            C_LE:    w_cond_true = w_z | ~w_ge;
            C_AL:    w_cond_true = 1'b1;
            default: w_cond_true = 1'b0;  // 4'b1111 is reserved and never executes
        endcase
    end

    // Flag halves are written independently, only by an executing instruction
    assign w_wr_nz = FlagW[1] & r_cond_ex;
    assign w_wr_cv = FlagW[0] & r_cond_ex;

    // NZCV register: each half loads from the ALU bus or holds
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= FLAGS_RST;
        end else begin
            if (w_wr_nz) begin
                r_flags[3:2] <= ALUFlags[3:2];
            end
            if (w_wr_cv) begin
                r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // CondEx register: reloads the evaluated condition on every edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cond_ex <= 1'b0;
        end else begin
            r_cond_ex <= w_cond_true;
        end
    end

    // Write-enable gating; NextPC bypasses CondEx so fetch always advances,
    // but it is masked while reset is held so nothing escapes during reset
    always_comb begin
        PCWrite  = reset & ((PCS & r_cond_ex) | NextPC);
        RegWrite = RegW & r_cond_ex;
        MemWrite = MemW & r_cond_ex;
    end

    assign CondEx = r_cond_ex;
    assign Flags  = r_flags;

endmodule

// File: tb/tb_cond_unit.sv
// Testbench for cond_unit. Observed vector layout:
//   {Flags[3:0], CondEx, PCWrite, RegWrite, MemWrite}
module tb_cond_unit;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic [3:0] Flags;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp;

  cond_unit #(.FLAGS_RST(4'b0000)) dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .NextPC   (NextPC),
    .RegW     (RegW),
    .MemW     (MemW),
    .PCWrite  (PCWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .CondEx   (CondEx),
    .Flags    (Flags)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] obs();
    return {Flags, CondEx, PCWrite, RegWrite, MemWrite};
  endfunction

  // Reference condition table
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    FlagW = 2'b00; PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0;
    ALUFlags = 4'b0000;
  endtask

  // Leaves Flags=f, CondEx=1, Cond=AL
  task automatic load_flags(input logic [3:0] f);
    drive_idle();
    Cond = 4'b1110;
    tick();
    FlagW = 2'b11; ALUFlags = f;
    tick();
    FlagW = 2'b00; ALUFlags = 4'b0000;
  endtask

  task automatic test_reset();
    reset = 1'b0; Cond = 4'b1110; ALUFlags = 4'b1111; FlagW = 2'b11;
    RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; NextPC = 1'b0;
    #1;
    exp_q.push_back({4'b0000, 1'b0, 3'b000});
    exp = exp_q.pop_front(); n_checks++;
    if (obs() !== exp) begin n_errors++; $display("FAIL reset_state: got %b want %b", obs(), exp); end
    NextPC = 1'b1;
    tick();
    exp_q.push_back({4'b0000, 1'b0, 3'b000});
    exp = exp_q.pop_front(); n_checks++;
    if (obs() !== exp) begin n_errors++; $display("FAIL reset_hold_nextpc: got %b want %b", obs(), exp); end
    NextPC = 1'b0; FlagW = 2'b00;
    reset = 1'b1;
    exp_q.push_back({4'b0000, 1'b1, 3'b111});
    tick();
    exp = exp_q.pop_front(); n_checks++;
    if (obs() !== exp) begin n_errors++; $display("FAIL reset_release: got %b want %b", obs(), exp); end
  endtask

  task automatic test_flag_load();
    drive_idle();
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0110;
    exp_q.push_back({4'b0110, 1'b1, 3'b000});
    tick();
    exp = exp_q.pop_front(); n_checks++;
    if (obs() !== exp) begin n_errors++; $display("FAIL flag_load: got %b want %b", obs(), exp); end
    FlagW = 2'b00; Cond = 4'b0000;
    exp_q.push_back({4'b0110, 1'b1, 3'b000});
    tick();
    exp = exp_q.pop_front(); n_checks++;
    if (obs() !== exp) begin n_errors++; $display("FAIL flag_load_eq: got %b want %b", obs(), exp); end
    Cond = 4'b0001;
    exp_q.push_back({4'b0110, 1'b0, 3'b000});
    tick();
    exp = exp_q.pop_front(); n_checks++;
    if (obs() !== exp) begin n_errors++; $display("FAIL flag_load_ne: got %b want %b", obs(), exp); end
  endtask

  task automatic test_split_write();
    load_flags(4'b0000);
    FlagW = 2'b10; ALUFlags = 4'b1111;
    exp_q.push_back({4'b1100, 1'b1, 3'b000});
    tick();
    exp = exp_q.pop_front(); n_checks++;
    if (obs() !== exp) begin n_errors++; $display("FAIL split_nz: got %b want %b", obs(), exp); end
    FlagW = 2'b01; ALUFlags = 4'b0001;
    exp_q.push_back({4'b1101, 1'b1, 3'b000});
    tick();
    exp = exp_q.pop_front(); n_checks++;
    if (obs() !== exp) begin n_errors++; $display("FAIL split_cv: got %b want %b", obs(), exp); end
  endtask

  task automatic test_signed_compares();
    logic [3:0] flg[11]  = '{4'b1001, 4'b1001, 4'b1001, 4'b1001,
                             4'b1000, 4'b1000, 4'b1000,
                             4'b0100, 4'b0100, 4'b0100, 4'b0100};
    logic [3:0] cnd[11]  = '{4'hA, 4'hB, 4'hC, 4'hD,
                             4'hA, 4'hB, 4'hD,
                             4'hC, 4'hD, 4'h8, 4'h9};
    logic       res[11]  = '{1'b1, 1'b0, 1'b1, 1'b0,
                             1'b0, 1'b1, 1'b1,
                             1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 11; i++) begin
      if (i == 0 || flg[i] != flg[i-1]) load_flags(flg[i]);
      Cond = cnd[i];
      exp_q.push_back({flg[i], res[i], 3'b000});
      tick();
      exp = exp_q.pop_front(); n_checks++;
      if (obs() !== exp) begin
        n_errors++;
        $display("FAIL signed_cmp[%0d] cond=%h: got %b want %b", i, cnd[i], obs(), exp);
      end
    end
  endtask

  task automatic test_suppressed();
    load_flags(4'b0000);
    Cond = 4'b0000;
    tick();
    RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1111; NextPC = 1'b0;
    exp_q.push_back({4'b0000, 1'b0, 3'b000});
    tick();
    exp = exp_q.pop_front(); n_checks++;
    if (obs() !== exp) begin n_errors++; $display("FAIL suppressed: got %b want %b", obs(), exp); end
    NextPC = 1'b1;
    #1;
    exp_q.push_back({4'b0000, 1'b0, 3'b100});
    exp = exp_q.pop_front(); n_checks++;
    if (obs() !== exp) begin n_errors++; $display("FAIL suppressed_nextpc: got %b want %b", obs(), exp); end
    drive_idle();
  endtask

  task automatic test_same_cycle();
    load_flags(4'b0000);
    Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b0100;
    exp_q.push_back({4'b0100, 1'b0, 3'b000});
    tick();
    exp = exp_q.pop_front(); n_checks++;
    if (obs() !== exp) begin n_errors++; $display("FAIL same_cycle: got %b want %b", obs(), exp); end
    FlagW = 2'b00;
    exp_q.push_back({4'b0100, 1'b1, 3'b000});
    tick();
    exp = exp_q.pop_front(); n_checks++;
    if (obs() !== exp) begin n_errors++; $display("FAIL same_cycle_next: got %b want %b", obs(), exp); end
    // A Cond change between edges must not move CondEx until the edge
    Cond = 4'b1111;
    #2;
    exp_q.push_back({4'b0100, 1'b1, 3'b000});
    exp = exp_q.pop_front(); n_checks++;
    if (obs() !== exp) begin n_errors++; $display("FAIL cond_between_edges: got %b want %b", obs(), exp); end
    exp_q.push_back({4'b0100, 1'b0, 3'b000});
    tick();
    exp = exp_q.pop_front(); n_checks++;
    if (obs() !== exp) begin n_errors++; $display("FAIL reserved_cond: got %b want %b", obs(), exp); end
  endtask

  task automatic test_async_reset();
    load_flags(4'b1010);
    RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; NextPC = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    exp_q.push_back({4'b0000, 1'b0, 3'b000});
    exp = exp_q.pop_front(); n_checks++;
    if (obs() !== exp) begin n_errors++; $display("FAIL async_reset: got %b want %b", obs(), exp); end
    NextPC = 1'b0;
    reset = 1'b1;
    exp_q.push_back({4'b0000, 1'b1, 3'b111});
    tick();
    exp = exp_q.pop_front(); n_checks++;
    if (obs() !== exp) begin n_errors++; $display("FAIL async_reset_release: got %b want %b", obs(), exp); end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    logic [3:0] m_flags;
    logic       m_cex;
    logic [3:0] nf;
    logic       nc;
    load_flags(4'b0000);
    m_flags = 4'b0000;
    m_cex   = 1'b1;
    for (int i = 0; i < 300; i++) begin
      Cond     = 4'($urandom_range(0, 15));
      ALUFlags = 4'($urandom_range(0, 15));
      FlagW    = 2'($urandom_range(0, 3));
      PCS      = 1'($urandom_range(0, 1));
      NextPC   = 1'($urandom_range(0, 1));
      RegW     = 1'($urandom_range(0, 1));
      MemW     = 1'($urandom_range(0, 1));
      nf = m_flags;
      if (FlagW[1] && m_cex) nf[3:2] = ALUFlags[3:2];
      if (FlagW[0] && m_cex) nf[1:0] = ALUFlags[1:0];
      nc = cond_eval(Cond, m_flags);
      exp_q.push_back({nf, nc, (PCS & nc) | NextPC, RegW & nc, MemW & nc});
      m_flags = nf;
      m_cex   = nc;
      tick();
      exp = exp_q.pop_front(); n_checks++;
      if (obs() !== exp) begin
        n_errors++;
        $display("FAIL back_to_back[%0d]: got %b want %b", i, obs(), exp);
      end
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_flag_load();
    test_split_write();
    test_signed_compares();
    test_suppressed();
    test_same_cycle();
    test_async_reset();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
